// File: rtl/enc_pkg.sv
// Shared encode/decode definitions for the 8-line event encoder and its downstream decoder.
// Holds the line count, code width, FSM encodings and the one-hot/select helpers.
package enc_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Decoder side of the path: binary index to line select.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

    // Lowest set index wins; returns 0 for an empty mask.
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_sel8.sv
// Combinational 8-way priority select with a rotating start point.
// The search begins at 'start' and wraps 7->0; start=0 gives plain lowest-index-first.
module prio_sel8
    import enc_pkg::*;
(
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;

    always_comb begin
        // Doubling the mask turns the wrap-around into a plain part-select.
        w_dbl = {mask, mask};
        w_rot = w_dbl[start +: N];
        w_off = sel(w_rot);
        idx   = start + w_off;
        any   = |mask;
    end

endmodule

// File: rtl/priority_encoder83.sv
// Registered 8-to-3 priority event encoder with valid/ready output handshake.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index-first.
module priority_encoder83
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ready,
    output logic             valid,
    output logic [IDX_W-1:0] code,
    output logic [N-1:0]     pend,
    output logic             ovf
);

    state_t           r_state;
    logic [N-1:0]     r_req_q;
    logic [N-1:0]     r_pend;
    logic [IDX_W-1:0] r_code;
    logic             r_valid;
    logic             r_ovf;

    logic             w_hs;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_sel_set;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    always_comb begin
        w_hs      = r_valid & ready;
        w_clr     = w_hs ? onehot(r_code) : '0;
        w_rise    = req & ~r_req_q;
        // Only registered pend is eligible; this cycle's rise competes next cycle.
        w_sel_set = r_pend & ~w_clr;
    end

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_last;

    // Reset value 7 makes the first search after reset start at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IDX_W'(N - 1);
        end else if (w_hs) begin
            r_last <= r_code;
        end
    end

    assign w_start = r_last + IDX_W'(1);
`else
    assign w_start = '0;
`endif

    prio_sel8 u_sel (
        .mask  (w_sel_set),
        .start (w_start),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_code  <= '0;
            r_pend  <= '0;
            r_req_q <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_req_q <= req;
            // A rise on a bit being cleared re-arms it.
            r_pend  <= w_sel_set | w_rise;
            r_ovf   <= |(w_rise & w_sel_set);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_code  <= w_idx;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ready) begin
                        if (w_any) begin
                            r_code <= w_idx;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign code  = r_code;
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_priority_encoder83.sv
// Scoreboard bench for priority_encoder83: expected codes are queued at stimulus time and
// popped by a monitor on every accepted handshake. Honours ROUND_ROBIN_EN for expectations.
module tb_priority_encoder83;
    import enc_pkg::*;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req   = '0;
    logic             ready = 1'b0;
    logic             valid;
    logic [IDX_W-1:0] code;
    logic [N-1:0]     pend;
    logic             ovf;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;
    logic [IDX_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    priority_encoder83 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
        .valid (valid),
        .code  (code),
        .pend  (pend),
        .ovf   (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every accepted code must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ovf) ovf_cnt++;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code: got %0d, required no handshake", code);
            end else begin
                chk("handshake_code", 32'(code), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        exp_q.delete();
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!valid && n < max_cyc) begin
            tick(1);
            n++;
        end
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL %s: valid=0 after %0d cycles, required 1", name, max_cyc);
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        ready = 1'b1;
        while ((valid || exp_q.size() != 0) && n < max_cyc) begin
            tick(1);
            n++;
        end
        ready = 1'b0;
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_valid_end"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int base;

        // 1: reset state held for 5 cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_code", 32'(code), 32'd0);
            chk("rst_pend", 32'(pend), 32'd0);
            tick(1);
        end

        // 2: single event, two-edge latency
        do_reset();
        ready = 1'b1;
        req   = 8'h20;
        exp_q.push_back(3'd5);
        tick(1);
        req = '0;
        chk("t2_pend_set", 32'(pend), 32'h20);
        chk("t2_valid_early", 32'(valid), 32'd0);
        tick(1);
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_code", 32'(code), 32'd5);
        tick(1);
        chk("t2_valid_after", 32'(valid), 32'd0);
        chk("t2_pend_after", 32'(pend), 32'd0);

        // 3: backpressure and fixed ordering
        do_reset();
        req = 8'h44;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd6);
        tick(1);
        req = '0;
        tick(1);
        chk("t3_code_first", 32'(code), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t3_hold_valid", 32'(valid), 32'd1);
            chk("t3_hold_code", 32'(code), 32'd2);
        end
        ready = 1'b1;
        tick(1);
        chk("t3_code_second", 32'(code), 32'd6);
        tick(1);
        chk("t3_valid_end", 32'(valid), 32'd0);
        ready = 1'b0;

        // 4: re-rise on a pending bit merges and flags overflow
        do_reset();
        base = ovf_cnt;
        req  = 8'h02;
        exp_q.push_back(3'd1);
        tick(1);
        req = '0;
        tick(1);
        req = 8'h02;
        tick(1);
        chk("t4_ovf_pulse", 32'(ovf), 32'd1);
        req = '0;
        tick(1);
        chk("t4_ovf_low", 32'(ovf), 32'd0);
        tick(2);
        chk("t4_ovf_count", 32'(ovf_cnt - base), 32'd1);
        drain("t4", 20);
        chk("t4_pend_end", 32'(pend), 32'd0);

        // 5: clear and rise on the same bit in one cycle
        do_reset();
        req = 8'h10;
        exp_q.push_back(3'd4);
        tick(1);
        req = '0;
        wait_valid("t5_first", 10);
        chk("t5_code_first", 32'(code), 32'd4);
        ready = 1'b1;
        req   = 8'h10;
        exp_q.push_back(3'd4);
        tick(1);
        ready = 1'b0;
        req   = '0;
        chk("t5_pend_kept", 32'(pend), 32'h10);
        chk("t5_valid_gap", 32'(valid), 32'd0);
        tick(1);
        chk("t5_valid_again", 32'(valid), 32'd1);
        chk("t5_code_again", 32'(code), 32'd4);
        drain("t5", 20);

        // 6: full pend, then re-pend bit 0 while code 3 is presented
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 4; i++) exp_q.push_back(IDX_W'(i));
        tick(1);
        wait_valid("t6_first", 10);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        chk("t6_code3", 32'(code), 32'd3);
        req = 8'hFE;
        tick(1);
        req = 8'hFF;
        tick(2);
        chk("t6_pend0", 32'(pend[0]), 32'd1);
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
`else
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd7);
`endif
        drain("t6", 40);
        req = '0;

        // 7: asynchronous reset while presenting
        do_reset();
        req = 8'h08;
        exp_q.push_back(3'd3);
        tick(2);
        chk("t7_valid_pre", 32'(valid), 32'd1);
        chk("t7_code_pre", 32'(code), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid_async", 32'(valid), 32'd0);
        chk("t7_code_async", 32'(code), 32'd0);
        chk("t7_pend_async", 32'(pend), 32'd0);
        do_reset();
        tick(3);
        chk("t7_valid_idle", 32'(valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
